// File: rtl/seven_seg_scan_decoder_if.sv
// Display-pin bundle for the scanned 7-segment decoder: the scanned bus in,
// the reconstructed frame out.
interface seven_seg_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   an_n;
  logic [7:0]          seg;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   points;
  logic [DIGITS-1:0]   err_mask;
  logic                frame_valid;
  logic                stale;

  modport master (
    output an_n, seg,
    input  digits, points, err_mask, frame_valid, stale
  );

  modport slave (
    input  an_n, seg,
    output digits, points, err_mask, frame_valid, stale
  );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Receive-side decoder for a scanned active-low 7-segment bus: qualifies each digit dwell,
// decodes it back to BCD plus point, and publishes whole frames. Macro SEG_SCAN_TIMEOUT_EN adds stale detection.
module seven_seg_scan_decoder #(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                     clk,
  input logic                     rst,
  seven_seg_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  // A single-sample dwell would make "stable" meaningless; refuse such builds.
  if (STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("seven_seg_scan_decoder: STABLE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [DIGITS-1:0]   r_an_q, r_an_prev;
  logic [7:0]          r_seg_q, r_seg_prev;
  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_shadow_code;
  logic [DIGITS-1:0]   r_shadow_pt, r_shadow_err;
  logic [4*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]   r_points, r_err_mask;
  logic                r_frame_valid;

  logic [DIGITS-1:0]   w_low, w_onehot;
  logic                w_an_valid, w_same, w_capture, w_frame_done;
  logic [IW-1:0]       w_index;
  logic [3:0]          w_code;
  logic                w_err, w_point;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an_q     <= '1;
      r_an_prev  <= '1;
      r_seg_q    <= '1;
      r_seg_prev <= '1;
    end else begin
      r_an_q     <= bus.an_n;
      r_seg_q    <= bus.seg;
      r_an_prev  <= r_an_q;
      r_seg_prev <= r_seg_q;
    end
  end

  assign w_low      = ~r_an_q;
  assign w_an_valid = (w_low != '0) && ((w_low & (w_low - DIGITS'(1))) == '0);
  assign w_same     = (r_an_q == r_an_prev) && (r_seg_q == r_seg_prev);

  always_comb begin
    w_index = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_low[i]) w_index = IW'(i);
    end
  end

  // Blank (all segments dark) is a legal digit; any unknown lit pattern is flagged.
  always_comb begin
    w_err = 1'b0;
    case (r_seg_q[6:0])
      7'h40:   w_code = 4'h0;
      7'h79:   w_code = 4'h1;
      7'h24:   w_code = 4'h2;
      7'h30:   w_code = 4'h3;
      7'h19:   w_code = 4'h4;
      7'h12:   w_code = 4'h5;
      7'h02:   w_code = 4'h6;
      7'h78:   w_code = 4'h7;
      7'h00:   w_code = 4'h8;
      7'h10:   w_code = 4'h9;
      7'h7F:   w_code = 4'hF;
      default: begin
        w_code = 4'hE;
        w_err  = 1'b1;
      end
    endcase
  end

  assign w_point      = ~r_seg_q[7];
  assign w_onehot     = DIGITS'(1) << w_index;
  assign w_capture    = (r_state == SETTLE) && w_an_valid && w_same &&
                        (r_count == CW'(STABLE_CYCLES - 1));
  assign w_frame_done = w_capture && ((r_seen | w_onehot) == '1);

  // Dwell qualification, shadow capture and frame publish share one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_seen        <= '0;
      r_shadow_code <= '1;
      r_shadow_pt   <= '0;
      r_shadow_err  <= '0;
      r_digits      <= '1;
      r_points      <= '0;
      r_err_mask    <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_an_valid) begin
            r_state <= SETTLE;
            r_count <= CW'(1);
          end else begin
            r_count <= '0;
          end
        end
        SETTLE: begin
          if (!w_an_valid) begin
            r_state <= IDLE;
            r_count <= '0;
          end else if (!w_same) begin
            r_count <= CW'(1);
          end else if (w_capture) begin
            r_state <= CAPTURED;
            r_count <= CW'(STABLE_CYCLES);
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        CAPTURED: begin
          if (!w_same) begin
            r_state <= w_an_valid ? SETTLE : IDLE;
            r_count <= w_an_valid ? CW'(1) : '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase

      if (w_capture) begin
        r_shadow_code[4*w_index +: 4] <= w_code;
        r_shadow_pt[w_index]          <= w_point;
        r_shadow_err[w_index]         <= w_err;
        if (w_frame_done) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == w_index) begin
              r_digits[4*i +: 4] <= w_code;
              r_points[i]        <= w_point;
              r_err_mask[i]      <= w_err;
            end else begin
              r_digits[4*i +: 4] <= r_shadow_code[4*i +: 4];
              r_points[i]        <= r_shadow_pt[i];
              r_err_mask[i]      <= r_shadow_err[i];
            end
          end
          r_seen        <= '0;
          r_frame_valid <= 1'b1;
        end else begin
          r_seen <= r_seen | w_onehot;
        end
      end
    end
  end

  assign bus.digits      = r_digits;
  assign bus.points      = r_points;
  assign bus.err_mask    = r_err_mask;
  assign bus.frame_valid = r_frame_valid;

`ifdef SEG_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_timeout;
  logic          r_stale;

  // Saturating age of the last frame; stale latches until the next frame edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= '0;
      r_stale   <= 1'b0;
    end else if (w_frame_done) begin
      r_timeout <= '0;
      r_stale   <= 1'b0;
    end else if (r_timeout != TW'(TIMEOUT_CYCLES)) begin
      r_timeout <= r_timeout + TW'(1);
      if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) r_stale <= 1'b1;
    end
  end

  assign bus.stale = r_stale;
`else
  assign bus.stale = 1'b0;
`endif

endmodule
